// File: rtl/approx_mult_error_monitor.sv
// Error-statistics monitor for 8x8 approximate multipliers: ER/MED/WCE over a run of N_SAMPLES.
// Optional signed bias accumulator enabled by defining APPROX_MON_BIAS_EN.
module approx_mult_error_monitor #(
    parameter int N_SAMPLES = 65536,
    parameter int SUM_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       a,
    input  logic [7:0]       b,
    input  logic [15:0]      y_apx,
    output logic             busy,
    output logic             done,
    output logic [16:0]      sample_cnt,
    output logic [16:0]      err_cnt,
    output logic [SUM_W-1:0] ed_sum,
    output logic [15:0]      ed_max,
    output logic [7:0]       wc_a,
    output logic [7:0]       wc_b
`ifdef APPROX_MON_BIAS_EN
    ,
    output logic signed [SUM_W:0] bias_sum
`endif
);

    // state | meaning
    // IDLE  | waiting for the first start
    // RUN   | accepting samples
    // DRAIN | last sample accepted, waiting for it to reach the statistics
    // DONE  | statistics final and held until the next start
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [16:0] LAST_CNT = 17'(N_SAMPLES - 1);

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic        accept;
    logic        last_accept;
    logic        clear;

    logic        s1_vld;
    logic [7:0]  s1_a;
    logic [7:0]  s1_b;
    logic [15:0] s1_y;
    logic [15:0] s1_exact;

    logic [16:0]      diff;
    logic [15:0]      ed;
    logic [SUM_W:0]   sum_ext;
    logic [SUM_W-1:0] sum_nxt;

    assign in_ready    = (state == RUN);
    assign busy        = (state == RUN) || (state == DRAIN);
    assign done        = (state == DONE);
    assign accept      = in_valid && in_ready;
    assign last_accept = accept && (sample_cnt == LAST_CNT);
    assign clear       = start && ((state == IDLE) || (state == DONE));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_accept) state_nxt = DRAIN;
            // The final sample sits in S1 during DRAIN and lands in the statistics on this edge.
            DRAIN:   state_nxt = DONE;
            DONE:    if (start) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld   <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_y     <= '0;
            s1_exact <= '0;
        end else begin
            s1_vld <= accept;
            if (accept) begin
                s1_a     <= a;
                s1_b     <= b;
                s1_y     <= y_apx;
                s1_exact <= 16'(a * b);
            end
        end
    end

    // S2: error distance via a 17-bit subtract; the borrow selects the reversed difference.
    assign diff    = {1'b0, s1_exact} - {1'b0, s1_y};
    assign ed      = diff[16] ? (s1_y - s1_exact) : diff[15:0];
    assign sum_ext = {1'b0, ed_sum} + (SUM_W+1)'(ed);
    assign sum_nxt = sum_ext[SUM_W] ? {SUM_W{1'b1}} : sum_ext[SUM_W-1:0];

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            sample_cnt <= '0;
            err_cnt    <= '0;
            ed_sum     <= '0;
            ed_max     <= '0;
            wc_a       <= '0;
            wc_b       <= '0;
        end else begin
            if (accept) sample_cnt <= sample_cnt + 17'd1;
            if (s1_vld) begin
                err_cnt <= err_cnt + 17'(ed != 16'd0);
                ed_sum  <= sum_nxt;
                if (ed > ed_max) begin
                    ed_max <= ed;
                    wc_a   <= s1_a;
                    wc_b   <= s1_b;
                end
            end
        end
    end

`ifdef APPROX_MON_BIAS_EN
    localparam logic signed [SUM_W+1:0] BIAS_MAX = {2'b00, {SUM_W{1'b1}}};
    localparam logic signed [SUM_W+1:0] BIAS_MIN = {2'b11, {SUM_W{1'b0}}};

    logic signed [17:0]      bias_err;
    logic signed [SUM_W+1:0] bias_ext;

    assign bias_err = $signed({2'b00, s1_y}) - $signed({2'b00, s1_exact});
    assign bias_ext = $signed({bias_sum[SUM_W], bias_sum})
                    + $signed({{(SUM_W-16){bias_err[17]}}, bias_err});

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            bias_sum <= '0;
        end else if (s1_vld) begin
            if (bias_ext > BIAS_MAX)      bias_sum <= BIAS_MAX[SUM_W:0];
            else if (bias_ext < BIAS_MIN) bias_sum <= BIAS_MIN[SUM_W:0];
            else                          bias_sum <= bias_ext[SUM_W:0];
        end
    end
`endif

endmodule
